// File: rtl/varcic_pkg.sv
// varcic_pkg: shared helpers and rate clamp constants for the variable-rate CIC decimator
package varcic_pkg;
   localparam int MIN_DEC = 2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
   function automatic int growth(input int r, input int stages);
      return stages * clog2(r);
   endfunction
endpackage

// File: rtl/varcic_round_sat.sv
// varcic_round_sat: round-half-up, variable arithmetic right shift and saturation for one channel
module varcic_round_sat #(
   parameter int ACC_WIDTH = 48,
   parameter int OUT_WIDTH = 18,
   parameter int SH_WIDTH  = 8
) (
   input  logic signed [ACC_WIDTH-1:0] din,
   input  logic        [SH_WIDTH-1:0]  sh,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        clip
);
   localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;
   logic signed [ACC_WIDTH-1:0] rnd, v;
   always_comb begin
      rnd = (sh == '0) ? '0 : ACC_WIDTH'(1) << (sh - 1'b1);
      v = (din + rnd) >>> sh;
      clip = (v > MAX_V) || (v < MIN_V);
      dout = (v > MAX_V) ? MAX_V[OUT_WIDTH-1:0] : (v < MIN_V) ? MIN_V[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
   end
endmodule

// File: rtl/varcic_mc.sv
// varcic_mc: multi-channel runtime-variable-rate CIC decimator with gain, saturation and flush on rate change
module varcic_mc
   import varcic_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int STAGES    = 5,
   parameter int IN_WIDTH  = 18,
   parameter int OUT_WIDTH = 18,
   parameter int MAX_DEC   = 40,
   parameter int DEC_WIDTH = 6,
   parameter int ACC_WIDTH = 48
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [DEC_WIDTH-1:0]          decimation,
   input  logic [2:0]                    gain,
   input  logic                          in_strobe,
   input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
   output logic                          out_strobe,
   output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]           out_overflow,
   output logic                          dec_error,
   output logic                          settling
);
   localparam int SH_WIDTH = 8;
   localparam int SC_WIDTH = clog2(STAGES + 1);
   if (ACC_WIDTH < IN_WIDTH + STAGES * clog2(MAX_DEC)) begin : g_acc_chk
      $error("varcic_mc: ACC_WIDTH too small for IN_WIDTH+STAGES*clog2(MAX_DEC)");
   end
   logic [DEC_WIDTH-1:0] r_eff, dec_r, cnt;
   logic [SH_WIDTH-1:0] sh, sh_next;
   logic [SC_WIDTH-1:0] settle_cnt;
   logic [STAGES:0] tok;
   logic [CHANNELS*OUT_WIDTH-1:0] rs_data;
   logic [CHANNELS-1:0] rs_clip;
   logic change, launch;
   int shv;
   always_comb begin
      r_eff = decimation < DEC_WIDTH'(MIN_DEC) ? DEC_WIDTH'(MIN_DEC) :
              decimation > DEC_WIDTH'(MAX_DEC) ? DEC_WIDTH'(MAX_DEC) : decimation;
      change = r_eff != dec_r;
      launch = in_strobe && !change && cnt == dec_r - 1'b1;
      shv = IN_WIDTH + growth(int'(dec_r), STAGES) - OUT_WIDTH - int'(gain);
      sh_next = shv > 0 ? SH_WIDTH'(shv) : '0;
   end
   // tok[k] marks comb stage k busy this cycle; tok[STAGES] means the comb output is ready
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         dec_r <= '0;
         cnt <= '0;
         tok <= '0;
         sh <= '0;
         settle_cnt <= SC_WIDTH'(STAGES);
         out_strobe <= 1'b0;
         out_data <= '0;
         out_overflow <= '0;
         dec_error <= 1'b0;
         settling <= 1'b1;
      end else begin
         dec_error <= decimation != r_eff;
         sh <= sh_next;
         out_strobe <= 1'b0;
         if (change) begin
            dec_r <= r_eff;
            cnt <= '0;
            tok <= '0;
            out_overflow <= '0;
            settling <= 1'b1;
            settle_cnt <= SC_WIDTH'(STAGES);
         end else begin
            if (in_strobe) cnt <= launch ? '0 : cnt + 1'b1;
            tok <= {tok[STAGES-1:0], launch};
            if (tok[STAGES] && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            if (tok[STAGES] && settle_cnt == '0) begin
               out_strobe <= 1'b1;
               out_data <= rs_data;
               out_overflow <= out_overflow | rs_clip;
               settling <= 1'b0;
            end
         end
      end
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] ich [STAGES+1];
      logic signed [ACC_WIDTH-1:0] cch [STAGES+1];
      logic signed [ACC_WIDTH-1:0] samp;
      assign ich[0] = ACC_WIDTH'($signed(in_data[c*IN_WIDTH +: IN_WIDTH]));
      assign cch[0] = samp;
      always_ff @(posedge clock or negedge reset_n)
         if (!reset_n) samp <= '0;
         else if (change) samp <= '0;
         else if (launch) samp <= ich[STAGES];
      // integrators wrap modulo 2^ACC_WIDTH; the comb differences remain exact
      for (genvar s = 0; s < STAGES; s++) begin : g_st
         logic signed [ACC_WIDTH-1:0] acc, dly, dif;
         assign ich[s+1] = acc;
         assign cch[s+1] = dif;
         always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) {acc, dly, dif} <= '0;
            else if (change) {acc, dly, dif} <= '0;
            else begin
               if (in_strobe) acc <= acc + ich[s];
               if (tok[s]) begin
                  dif <= cch[s] - dly;
                  dly <= cch[s];
               end
            end
      end
      varcic_round_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SH_WIDTH(SH_WIDTH)) u_rs (
         .din (cch[STAGES]),
         .sh  (sh),
         .dout(rs_data[c*OUT_WIDTH +: OUT_WIDTH]),
         .clip(rs_clip[c])
      );
   end
endmodule

// File: tb/tb_varcic_mc.sv
// tb_varcic_mc: scoreboard bench for the multi-channel variable-rate CIC decimator
module tb_varcic_mc;
   localparam int S = 5, IW = 18, OW = 18;
   logic clock = 1'b0, reset_n = 1'b0, in_strobe = 1'b1;
   logic [5:0] decimation = 6'd16;
   logic [2:0] gain = 3'd0;
   logic [2*IW-1:0] in_data = '0;
   logic out_strobe, dec_error, settling;
   logic [2*OW-1:0] out_data;
   logic [1:0] out_overflow;
   typedef struct { int d0; int d1; logic [1:0] ovf; int cyc; } exp_t;
   exp_t sbq[$];
   exp_t e;
   int cyc = 0, c0 = 0, checks = 0, failures = 0;
   varcic_mc dut (
      .clock(clock), .reset_n(reset_n), .decimation(decimation), .gain(gain),
      .in_strobe(in_strobe), .in_data(in_data), .out_strobe(out_strobe), .out_data(out_data),
      .out_overflow(out_overflow), .dec_error(dec_error), .settling(settling)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // monitor: every out_strobe must match the head of the scoreboard, including its cycle
   always @(negedge clock)
      if (reset_n && out_strobe === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got strobe at cycle %0d expected none", cyc);
         end else begin
            e = sbq.pop_front();
            check("out_cycle", cyc, e.cyc);
            check("ch0", $signed(out_data[OW-1:0]), e.d0);
            check("ch1", $signed(out_data[2*OW-1:OW]), e.d1);
            check("overflow", out_overflow, e.ovf);
            check("settling_at_out", settling, 0);
            check("no_x", $isunknown({out_data, out_overflow, dec_error, settling}), 0);
         end
      end
   task automatic set_cfg(input int r, input int g, input int x0, input int x1);
      @(posedge clock);
      #1;
      decimation = 6'(r);
      gain = 3'(g);
      in_data = {IW'(x1), IW'(x0)};
      c0 = cyc;
   endtask
   // first real output comes with token STAGES+1, STAGES+2 clocks after its completing strobe
   task automatic expect_n(input int r, input int n, input int d0, input int d1, input logic [1:0] ovf);
      for (int j = 0; j < n; j++) sbq.push_back('{d0, d1, ovf, c0 + (S + 1) * r + S + 2 + j * r});
   endtask
   task automatic drain(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         #1;
         n++;
      end while (sbq.size() != 0 && n < limit);
      check("drain_pending", sbq.size(), 0);
      sbq.delete();
   endtask
   initial begin
      in_data = {IW'(-500), IW'(1000)};
      repeat (3) @(posedge clock);
      #1;
      check("rst_strobe", out_strobe, 0);
      check("rst_data", out_data, 0);
      check("rst_ovf", out_overflow, 0);
      check("rst_dec_error", dec_error, 0);
      check("rst_settling", settling, 1);
      reset_n = 1'b1;
      c0 = cyc;
      expect_n(16, 4, 1000, -500, 2'b00);
      @(posedge clock);
      #1;
      check("settling_after_rst", settling, 1);
      drain(600);
      set_cfg(10, 0, 1000, 0);
      expect_n(10, 3, 95, 0, 2'b00);
      drain(600);
      set_cfg(16, 3, 20000, 0);
      expect_n(16, 3, 131071, 0, 2'b01);
      drain(600);
      set_cfg(8, 0, 1000, 0);
      expect_n(8, 3, 1000, 0, 2'b00);
      @(posedge clock);
      #1;
      check("settling_on_change", settling, 1);
      check("ovf_cleared_on_change", out_overflow, 0);
      drain(600);
      set_cfg(1, 0, 1000, -1000);
      expect_n(2, 4, 1000, -1000, 2'b00);
      @(posedge clock);
      #1;
      check("dec_error_low", dec_error, 1);
      drain(600);
      set_cfg(50, 0, 1000, -1000);
      expect_n(40, 3, 95, -95, 2'b00);
      @(posedge clock);
      #1;
      check("dec_error_high", dec_error, 1);
      drain(800);
      set_cfg(16, 0, 1000, -500);
      repeat (100) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_strobe", out_strobe, 0);
      check("arst_data", out_data, 0);
      check("arst_ovf", out_overflow, 0);
      check("arst_dec_error", dec_error, 0);
      check("arst_settling", settling, 1);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      c0 = cyc;
      expect_n(16, 3, 1000, -500, 2'b00);
      drain(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
